rx_uart: RTL and testbench
==========================

# rx_uart

Serial UART receiver for the peripherals/uart block. It recovers 8N1 (or 8E1/8O1) frames from the asynchronous `i_rx` line using a fixed clocks-per-bit oversampling counter. Each byte is presented on a single-entry valid/ready output register, together with per-byte error flags. It is the receiving end paired with the team's UART transmitter, and sits between the pad and the peripheral controller.

## Interface
- `CLKS_PER_BIT`, default 5: i_clk cycles per serial bit; legal range 3..255.
- `PARITY_EN`, default 0: 1 means a parity bit follows the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
- Derived `SAMPLE` = (CLKS_PER_BIT-1)/2, integer division; this is the mid-bit offset.
- `i_clk`  in  1: single clock; every register is in this domain.
- `i_rst`  in  1: asynchronous, active-low reset.
- `i_rx`  in  1: serial line; idles high; asynchronous to i_clk.
- `o_data`  out  8: received byte, valid while o_valid=1.
- `o_valid`  out  1: byte available; held until accepted.
- `i_ready`  in  1: consumer accepts the byte when o_valid & i_ready at a rising edge.
- `o_frame_err`  out  1: stop bit sampled low for the presented byte.
- `o_parity_err`  out  1: parity mismatch for the presented byte; always 0 when PARITY_EN=0.
- `o_overrun`  out  1: sticky; a completed frame was dropped because the output register was full.

## Operation
- `i_rx` passes through a 2-flop synchronizer, initialised to 1 on reset. Its output is `rx_s`.
- The FSM has six states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH. It uses an 8-bit `clk_count`, a 3-bit `bit_idx` and an 8-bit shift register.
- **IDLE:** when rx_s=0, go to START with clk_count←0.
- **START:** clk_count increments each cycle.
  - When clk_count==SAMPLE and rx_s=0: go to DATA with clk_count←0 and bit_idx←0.
  - When clk_count==SAMPLE and rx_s=1: the start was a glitch; go to IDLE, with no output and no flags.
- **DATA:** when clk_count==CLKS_PER_BIT-1, sample rx_s into the shift register LSB-first. Set clk_count←0 and bit_idx←bit_idx+1. After bit 7, go to PARITY if PARITY_EN, else STOP.
- **PARITY:** sample at clk_count==CLKS_PER_BIT-1.
  - perr = XOR(data bits, parity bit) XOR PARITY_ODD, where a nonzero result means mismatch.
  - Then go to STOP with clk_count←0.
- **STOP:** sample at clk_count==CLKS_PER_BIT-1. ferr = ~rx_s. Then deliver the frame as described in the delivery rules.
  - If rx_s=1, go to IDLE.
  - If rx_s=0, go to WAIT_HIGH. WAIT_HIGH returns to IDLE on the first cycle with rx_s=1. This prevents a break condition from retriggering start detection.
- **Delivery, on the stop-sample edge:**
  - If o_valid=0, or o_valid & i_ready in that same cycle: load o_data, o_frame_err and o_parity_err, and set o_valid←1.
  - Otherwise: drop the new frame, keep the old byte and flags unchanged, and set o_overrun←1.
- **Handshake:**
  - o_valid clears on o_valid & i_ready, unless a new frame loads in the same edge; in that case it stays 1 with the new data.
  - o_frame_err and o_parity_err are meaningful only while o_valid=1. They clear along with o_valid.
- **Overrun:** o_overrun clears on the next accepted handshake after it was set, or on reset. A new drop in the same edge as an accept takes priority, leaving o_overrun at 1.
- **Reset values:** o_data=0x00, o_valid=0, o_frame_err=0, o_parity_err=0, o_overrun=0, state=IDLE, all counters 0.
- **Reset mid-frame:** deassert is immediate and asynchronous. The partial frame is discarded, and reception restarts on the next falling edge seen after reset release.

## Timing
- rx_s lags i_rx by 2 cycles. Define T0 as the rising edge at which the FSM first sees rx_s=0.
- Start check happens at edge T0+SAMPLE+1.
- Data bit k (0..7) is sampled at T0+SAMPLE+1+(k+1)·CLKS_PER_BIT.
- The parity bit, if enabled, is sampled at T0+SAMPLE+1+9·CLKS_PER_BIT.
- The stop bit is sampled at T0+SAMPLE+1+(9+PARITY_EN)·CLKS_PER_BIT. o_valid is high immediately after that edge.
- Back-to-back frames: a start bit arriving immediately after a valid stop bit is detected without loss. IDLE is entered on the stop-sample edge, so the maximum line rate is sustained.
- The consumer may hold i_ready=1 permanently. In that case o_valid is a 1-cycle pulse per byte.

## Test plan
- **Single byte:** CLKS_PER_BIT=5, PARITY_EN=0, i_ready=1, send 0xA5 (8N1).
  - o_data=0xA5 and o_valid is a 1-cycle pulse at T0+48.
  - o_frame_err=0.
- **Glitch rejection:** i_rx low for 2 cycles, then high.
  - No state leaves IDLE past START and o_valid stays 0.
  - A following 0x3C is then received correctly.
- **Parity:** PARITY_EN=1, PARITY_ODD=0.
  - Send 0x07 with parity bit 1: o_parity_err=0.
  - Send 0x07 with parity bit 0: o_parity_err=1, o_valid=1, o_data=0x07.
- **Framing and break:** send 0x55 with stop bit 0, then hold i_rx low for 30 cycles.
  - Exactly one o_valid, with o_frame_err=1.
  - No second frame while the line is low.
  - After i_rx returns high, 0x81 is received cleanly.
- **Backpressure and overrun:** i_ready=0, send 0x11 then 0x22 back-to-back.
  - o_data stays 0x11 and o_overrun=1.
  - Raise i_ready: one handshake on 0x11, o_valid→0, o_overrun→0.
  - With i_ready=1 on the stop-sample edge of a new frame: seamless reload, o_valid held at 1.
- **Async reset mid-frame:** assert i_rst=0 during DATA bit 4.
  - All outputs go to their reset values immediately.
  - After release, a fresh 0xF0 is received correctly.

Source files
------------

// File: rtl/rx_uart.sv
// UART receiver: 2-flop synchronised serial input, mid-bit sampling FSM and a
// single-entry valid/ready output register with per-byte framing/parity flags.
module rx_uart #(
   parameter int CLKS_PER_BIT = 5,
   parameter bit PARITY_EN    = 1'b0,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_frame_err,
   output logic       o_parity_err,
   output logic       o_overrun
);

   localparam logic [7:0] SAMPLE = 8'((CLKS_PER_BIT - 1) / 2);
   localparam logic [7:0] LAST   = 8'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

   state_t     state;
   logic [7:0] clk_count;
   logic [2:0] bit_idx;
   logic [7:0] shreg;
   logic       rx_m, rx_s;
   logic       perr_q;
   logic       accept, stop_hit, load;

   function automatic logic parity_err(input logic [7:0] d, input logic pbit);
      return (^d) ^ pbit ^ PARITY_ODD;
   endfunction

   assign accept   = o_valid & i_ready;
   assign stop_hit = (state == STOP) && (clk_count == LAST);
   // A full register still loads when the consumer takes the old byte on the same edge.
   assign load     = stop_hit && (!o_valid || i_ready);

   // Synchroniser: line idles high, so reset to 1 to avoid a false start.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= i_rx;
         rx_s <= rx_m;
      end
   end

   // Data shift register, LSB first.
   always_ff @(posedge i_clk) begin
      if (state == DATA && clk_count == LAST)
         shreg <= {rx_s, shreg[7:1]};
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state     <= IDLE;
         clk_count <= 8'd0;
         bit_idx   <= 3'd0;
         perr_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state     <= START;
                  clk_count <= 8'd0;
               end
            end
            START: begin
               if (clk_count == SAMPLE) begin
                  clk_count <= 8'd0;
                  bit_idx   <= 3'd0;
                  state     <= rx_s ? IDLE : DATA;
               end else begin
                  clk_count <= clk_count + 8'd1;
               end
            end
            DATA: begin
               if (clk_count == LAST) begin
                  clk_count <= 8'd0;
                  bit_idx   <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7)
                     state <= PARITY_EN ? PARITY : STOP;
               end else begin
                  clk_count <= clk_count + 8'd1;
               end
            end
            PARITY: begin
               if (clk_count == LAST) begin
                  perr_q    <= parity_err(shreg, rx_s);
                  clk_count <= 8'd0;
                  state     <= STOP;
               end else begin
                  clk_count <= clk_count + 8'd1;
               end
            end
            STOP: begin
               if (clk_count == LAST) begin
                  clk_count <= 8'd0;
                  // A low stop bit may be a break; wait for the line to recover.
                  state     <= rx_s ? IDLE : WAIT_HIGH;
               end else begin
                  clk_count <= clk_count + 8'd1;
               end
            end
            WAIT_HIGH: begin
               if (rx_s)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_data       <= 8'h00;
         o_valid      <= 1'b0;
         o_frame_err  <= 1'b0;
         o_parity_err <= 1'b0;
         o_overrun    <= 1'b0;
      end else begin
         if (load) begin
            o_data       <= shreg;
            o_valid      <= 1'b1;
            o_frame_err  <= ~rx_s;
            o_parity_err <= PARITY_EN && perr_q;
         end else if (accept) begin
            o_valid      <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
         end
         if (stop_hit && !load)
            o_overrun <= 1'b1;
         else if (accept)
            o_overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rx_uart.sv
// Directed bench for rx_uart: 8N1 instance plus an 8E1 instance for parity cases.
module tb_rx_uart;

   localparam int CPB = 5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx, rx_p;
   logic       rdy;
   logic [7:0] d, d_p;
   logic       v, v_p, fe, fe_p, pe, pe_p, ov, ov_p;
   int         n_err = 0;
   int         n_chk = 0;
   int         pulses;

   always #5 clk = ~clk;

   rx_uart #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
      .i_clk(clk), .i_rst(rst_n), .i_rx(rx), .o_data(d), .o_valid(v),
      .i_ready(rdy), .o_frame_err(fe), .o_parity_err(pe), .o_overrun(ov));

   rx_uart #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
      .i_clk(clk), .i_rst(rst_n), .i_rx(rx_p), .o_data(d_p), .o_valid(v_p),
      .i_ready(rdy), .o_frame_err(fe_p), .o_parity_err(pe_p), .o_overrun(ov_p));

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input bit to_p, input logic b);
      if (to_p) rx_p = b; else rx = b;
      repeat (CPB) @(negedge clk);
   endtask

   // Returns one cycle before the stop-sample edge.
   task automatic send_frame(input bit to_p, input logic [7:0] dat, input bit par_on,
                             input logic pbit, input logic stop_b);
      drive_bit(to_p, 1'b0);
      for (int k = 0; k < 8; k++) drive_bit(to_p, dat[k]);
      if (par_on) drive_bit(to_p, pbit);
      drive_bit(to_p, stop_b);
   endtask

   initial begin
      rst_n = 1'b0;
      rx    = 1'b1;
      rx_p  = 1'b1;
      rdy   = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_data",  d,  8'h00);
      chk("rst_valid", v,  8'h0);
      chk("rst_ferr",  fe, 8'h0);
      chk("rst_perr",  pe, 8'h0);
      chk("rst_ovr",   ov, 8'h0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Single byte, pulse exactly after T0+48
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
      chk("a5_pre_valid", v, 8'h0);
      @(negedge clk);
      chk("a5_valid", v,  8'h1);
      chk("a5_data",  d,  8'hA5);
      chk("a5_ferr",  fe, 8'h0);
      @(negedge clk);
      chk("a5_pulse_end", v, 8'h0);

      // Glitch rejection
      repeat (4) @(negedge clk);
      rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (v) pulses++;
      end
      chk("glitch_no_valid", 8'(pulses), 8'd0);
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk("3c_valid", v, 8'h1);
      chk("3c_data",  d, 8'h3C);

      // Even parity on the 8E1 instance
      send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      chk("par_ok_valid", v_p,  8'h1);
      chk("par_ok_perr",  pe_p, 8'h0);
      repeat (3) @(negedge clk);
      send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      chk("par_bad_valid", v_p,  8'h1);
      chk("par_bad_data",  d_p,  8'h07);
      chk("par_bad_perr",  pe_p, 8'h1);

      // Framing error followed by a break
      repeat (3) @(negedge clk);
      send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("brk_valid", v,  8'h1);
      chk("brk_data",  d,  8'h55);
      chk("brk_ferr",  fe, 8'h1);
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (v) pulses++;
      end
      chk("brk_no_retrigger", 8'(pulses), 8'd0);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk("81_data", d,  8'h81);
      chk("81_ferr", fe, 8'h0);

      // Backpressure and overrun
      repeat (3) @(negedge clk);
      rdy = 1'b0;
      send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
      send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
      chk("ovr_pre", ov, 8'h0);
      @(negedge clk);
      chk("ovr_valid", v,  8'h1);
      chk("ovr_data",  d,  8'h11);
      chk("ovr_flag",  ov, 8'h1);
      rdy = 1'b1;
      @(negedge clk);
      chk("ovr_acc_valid", v,  8'h0);
      chk("ovr_acc_clear", ov, 8'h0);

      // Seamless reload: accept and load on the same edge
      rdy = 1'b0;
      send_frame(1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
      send_frame(1'b0, 8'h44, 1'b0, 1'b0, 1'b1);
      chk("reload_old_data", d, 8'h33);
      rdy = 1'b1;
      @(negedge clk);
      chk("reload_valid", v,  8'h1);
      chk("reload_data",  d,  8'h44);
      chk("reload_novr",  ov, 8'h0);
      @(negedge clk);
      chk("reload_drain", v, 8'h0);

      // Asynchronous reset during data bit 4
      rdy = 1'b0;
      send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk("prerst_valid", v, 8'h1);
      drive_bit(1'b0, 1'b0);
      for (int k = 0; k < 4; k++) drive_bit(1'b0, 1'b0);
      rx = 1'b1;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_valid", v,  8'h0);
      chk("arst_data",  d,  8'h00);
      chk("arst_ferr",  fe, 8'h0);
      chk("arst_perr",  pe, 8'h0);
      chk("arst_ovr",   ov, 8'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      rdy   = 1'b1;
      repeat (3) @(negedge clk);
      send_frame(1'b0, 8'hF0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk("f0_valid", v, 8'h1);
      chk("f0_data",  d, 8'hF0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
